// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback path: register-file geometry,
// the writeback request record and the arbitration grant encoding.
package writeback_unit_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

  // One-hot register mask; x0 never tracks a pending write so it maps to zero.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    reg_onehot = '0;
    if (rd != '0) reg_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: loads win by default, the ALU wins once it has
// been passed over STARVE_LIMIT times in a row.
module wb_arbiter
  import writeback_unit_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   alu_valid,
  input  logic   lsu_valid,
  output logic   alu_ready,
  output logic   lsu_ready,
  output grant_e grant
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          alu_win;
  logic          lsu_win;

  always_comb begin
    alu_win   = alu_valid && (!lsu_valid || (starve_cnt == LIMIT));
    lsu_win   = lsu_valid && !alu_win;
    alu_ready = alu_win && !reset;
    lsu_ready = lsu_win && !reset;
    grant     = alu_ready ? GNT_ALU : (lsu_ready ? GNT_LSU : GNT_NONE);
  end

  // Counts only cycles where the ALU was actually waiting and lost.
  always_ff @(posedge clock) begin
    if (reset)
      starve_cnt <= '0;
    else if (alu_ready)
      starve_cnt <= '0;
    else if (alu_valid && lsu_ready && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: arbitrates ALU/LSU results, registers the
// winning write for one cycle and tracks pending destinations in busy_mask.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [REG_ADDR_W-1:0] write_port,
  output logic [XLEN-1:0]       write_data,
  output logic                  write_enable,
  output logic [NUM_REGS-1:0]   busy_mask
);

  grant_e                grant;
  logic                  acc;
  wb_req_t               acc_req;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;
  logic [NUM_REGS-1:0]   busy_next;

  wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .alu_ready (alu_ready),
    .lsu_ready (lsu_ready),
    .grant     (grant)
  );

  always_comb begin
    acc     = (grant != GNT_NONE);
    acc_req = (grant == GNT_ALU) ? wb_req_t'{rd: alu_rd, data: alu_data}
                                 : wb_req_t'{rd: lsu_rd, data: lsu_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_port   <= '0;
      write_data   <= '0;
    end else if (acc) begin
      write_enable <= (acc_req.rd != '0);
      write_port   <= acc_req.rd;
      write_data   <= acc_req.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Set beats clear so a re-issue racing its own older writeback stays pending.
  always_comb begin
    set_mask     = issue_valid ? reg_onehot(issue_rd) : '0;
    clr_mask     = acc ? reg_onehot(acc_req.rd) : '0;
    busy_next    = (busy_mask & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_next;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: the driver pushes hand-computed writebacks
// into a queue, a monitor pops and compares one cycle after each handshake.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, issue_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic [4:0]  write_port;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] busy_mask;

  typedef struct {
    logic        we;
    logic [4:0]  port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  writeback_unit #(.STARVE_LIMIT(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .write_port   (write_port),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy_mask    (busy_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] port, input logic [31:0] data);
    exp_t e;
    e.we = we; e.port = port; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; alu_data = 0; lsu_data = 0;
  endtask

  // Monitor: samples the handshake after inputs settle, checks outputs next cycle.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept actual=handshake required=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_enable", {31'b0, write_enable}, {31'b0, e.we});
          chk("wb_port",   {27'b0, write_port},   {27'b0, e.port});
          chk("wb_data",   write_data,            e.data);
        end
      end
      #2;
      pend = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
    end
  end

  // Driver with hand-computed expectations.
  initial begin : driver
    logic exp_alu_gnt [5];
    exp_alu_gnt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    alu_valid = 1; lsu_valid = 1;
    #1;
    chk("rst_we",        {31'b0, write_enable}, 32'h0);
    chk("rst_port",      {27'b0, write_port},   32'h0);
    chk("rst_data",      write_data,            32'h0);
    chk("rst_busy",      busy_mask,             32'h0);
    chk("rst_alu_ready", {31'b0, alu_ready},    32'h0);
    chk("rst_lsu_ready", {31'b0, lsu_ready},    32'h0);

    // Lone load result.
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hDEADBEEF;
    #1;
    chk("lsu_alone_ready", {31'b0, lsu_ready}, 32'h1);
    chk("lsu_alone_alu",   {31'b0, alu_ready}, 32'h0);
    push(1'b1, 5'd5, 32'hDEADBEEF);

    // Idle cycle: output registers hold, strobe drops.
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    #1;
    chk("idle_we",   {31'b0, write_enable}, 32'h0);
    chk("idle_port", {27'b0, write_port},   32'd5);
    chk("idle_data", write_data,            32'hDEADBEEF);

    // Both sources contend for five cycles: L,L,L,A,L.
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clock);
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA000_0000 + i;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'hB000_0000 + i;
      #1;
      chk($sformatf("starve_alu_ready%0d", i), {31'b0, alu_ready}, {31'b0, exp_alu_gnt[i]});
      chk($sformatf("starve_lsu_ready%0d", i), {31'b0, lsu_ready}, {31'b0, ~exp_alu_gnt[i]});
      if (exp_alu_gnt[i]) push(1'b1, 5'd1, 32'hA000_0000 + i);
      else                push(1'b1, 5'd2, 32'hB000_0000 + i);
    end

    // Issue rd7, ALU writes it back two cycles later.
    @(negedge clock);
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd7;
    @(negedge clock);
    idle_inputs();
    chk("busy7_c1", busy_mask, 32'h0000_0080);
    @(negedge clock);
    chk("busy7_c2", busy_mask, 32'h0000_0080);
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    chk("rd7_alu_ready", {31'b0, alu_ready}, 32'h1);
    push(1'b1, 5'd7, 32'h77);
    @(negedge clock);
    idle_inputs();
    chk("busy7_clear", busy_mask, 32'h0);

    // Make rd12 pending, then ALU writes x0 while x0 is also issued.
    issue_valid = 1; issue_rd = 5'd12;
    @(negedge clock);
    idle_inputs();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    issue_valid = 1; issue_rd = 5'd0;
    #1;
    chk("rd0_alu_ready", {31'b0, alu_ready}, 32'h1);
    push(1'b0, 5'd0, 32'h1234);
    @(negedge clock);
    idle_inputs();
    chk("rd0_busy_same", busy_mask, 32'h0000_1000);

    // Issue and LSU writeback of rd9 coincide: set wins.
    issue_valid = 1; issue_rd = 5'd9;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
    #1;
    chk("rd9_lsu_ready", {31'b0, lsu_ready}, 32'h1);
    push(1'b1, 5'd9, 32'h99);
    @(negedge clock);
    idle_inputs();
    chk("rd9_set_wins", busy_mask, 32'h0000_1200);

    // Re-issue busy rd12; single writeback clears it.
    issue_valid = 1; issue_rd = 5'd12;
    @(negedge clock);
    idle_inputs();
    chk("rd12_reissue", busy_mask, 32'h0000_1200);
    lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC12;
    push(1'b1, 5'd12, 32'hC12);
    @(negedge clock);
    idle_inputs();
    chk("rd12_clear", busy_mask, 32'h0000_0200);

    // Accept rd3, then reset the next cycle with both sources still offering.
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33;
    push(1'b1, 5'd3, 32'h33);
    @(negedge clock);
    reset = 1'b1;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
    lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'h66;
    #1;
    chk("rst2_alu_ready", {31'b0, alu_ready}, 32'h0);
    chk("rst2_lsu_ready", {31'b0, lsu_ready}, 32'h0);
    @(negedge clock);
    #1;
    chk("rst2_we",   {31'b0, write_enable}, 32'h0);
    chk("rst2_busy", busy_mask,             32'h0);
    chk("rst2_port", {27'b0, write_port},   32'h0);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #20000;
    join_any
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout actual=running required=done t=%0t", $time);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 3, consecutive lost arbitrations after which the ALU source wins.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: alu_valid  input  1  ALU result offered.
REQ-005 SHALL have port: alu_ready  output  1  ALU result accepted this cycle.
REQ-006 SHALL have port: alu_rd  input  5  ALU destination register.
REQ-007 SHALL have port: alu_data  input  32  ALU result value.
REQ-008 SHALL have port: lsu_valid  input  1  load result offered.
REQ-009 SHALL have port: lsu_ready  output  1  load result accepted this cycle.
REQ-010 SHALL have port: lsu_rd  input  5  load destination register.
REQ-011 SHALL have port: lsu_data  input  32  load result value.
REQ-012 SHALL have port: issue_valid  input  1  instruction issued that will write issue_rd.
REQ-013 SHALL have port: issue_rd  input  5  destination register of the issued instruction.
REQ-014 SHALL have port: write_port  output  5  register-file write address.
REQ-015 SHALL have port: write_data  output  32  register-file write data.
REQ-016 SHALL have port: write_enable  output  1  register-file write strobe.
REQ-017 SHALL have port: busy_mask  output  32  bit n set = register n has a pending write.

Function
REQ-018 A source SHALL be accepted only in a cycle where its valid and ready are both 1; at most one source SHALL be accepted per cycle.
REQ-019 Ready SHALL be combinational from alu_valid, lsu_valid and the starvation counter; sources SHALL NOT make valid depend on ready.
REQ-020 Arbitration: LSU wins when lsu_valid=1, except when the starvation counter equals STARVE_LIMIT and alu_valid=1, in which case ALU wins.
REQ-021 ALU SHALL win whenever alu_valid=1 and lsu_valid=0.
REQ-022 Starvation counter SHALL increment (saturating at STARVE_LIMIT) on each cycle with alu_valid=1 and LSU accepted, and SHALL clear to 0 on ALU acceptance.
REQ-023 The counter SHALL hold its value when alu_valid=0.
REQ-024 An accepted result SHALL appear on write_port/write_data exactly one cycle after acceptance (one-cycle latency, registered outputs).
REQ-025 write_enable SHALL be 1 in that cycle only if the accepted rd is non-zero.
REQ-026 A result with rd=0 SHALL be accepted and SHALL clear nothing.
REQ-027 In cycles following no acceptance, write_enable SHALL be 0 and write_port/write_data SHALL hold their previous values.
REQ-028 busy_mask bit rd SHALL be set at the clock edge where issue_valid=1 and issue_rd!=0.
REQ-029 busy_mask bit rd SHALL be cleared at the clock edge where a result for rd is accepted.
REQ-030 If issue and acceptance of the same rd coincide, set SHALL win.
REQ-031 Re-issue to an already-busy rd SHALL leave the bit at 1; the bit SHALL clear on the next writeback to that rd (single bit, no count).
REQ-032 busy_mask[0] SHALL be 0 at all times.

Reset
REQ-033 While reset=1 at an edge: write_enable, write_port, write_data, busy_mask and the starvation counter SHALL be 0 after that edge.
REQ-034 alu_ready and lsu_ready SHALL be 0 in any cycle with reset=1, and no acceptance SHALL occur.
REQ-035 A result accepted in the cycle before reset asserts SHALL be discarded; write_enable SHALL be 0 after the reset edge.

Structure
REQ-036 A shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and typedef wb_req_t {rd, data}.
REQ-037 Arbitration and the starvation counter SHALL live in sub-module wb_arbiter; the scoreboard and output register SHALL stay in writeback_unit.

Verification
REQ-038 Bench: lsu_valid=1 rd=5 data=0xDEADBEEF alone -> lsu_ready=1; next cycle write_enable=1, write_port=5, write_data=0xDEADBEEF.
REQ-039 Bench: alu_valid and lsu_valid held high 5 cycles, STARVE_LIMIT=3 -> grant sequence LSU,LSU,LSU,ALU,LSU.
REQ-040 Bench: issue rd=7, then ALU writeback rd=7 two cycles later -> busy_mask[7] is 1 for two cycles, then 0 after the acceptance edge.
REQ-041 Bench: ALU result rd=0 data=0x1234 -> accepted; write_enable=0 next cycle; busy_mask unchanged.
REQ-042 Bench: issue rd=9 in the same cycle as LSU accepts rd=9 -> busy_mask[9]=1 afterwards.
REQ-043 Bench: accept rd=3 then assert reset next cycle -> write_enable=0, busy_mask=0, both readies 0 during reset.
